root_dispatch: RTL and testbench
================================

ROOT_DISPATCH -- requirements
Module: root_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth (power of 2, >=2) SHALL be supported.
REQ-002 Parameter TAG_W, default 4, width of the request tag SHALL be supported.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_data_1  input  10  radicand, unsigned integer.
REQ-006 in_data_2  input  3  root order.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 root_in_valid  output  1  one-cycle start pulse to the root engine.
REQ-009 root_data_1  output  10  radicand presented to the root engine.
REQ-010 root_data_2  output  3  order presented to the root engine.
REQ-011 root_out_valid  input  1  root engine result strobe.
REQ-012 root_out_data  input  20  root engine result, Q10.10.
REQ-013 out_valid  output  1  result available.
REQ-014 out_data  output  20  Q10.10 result.
REQ-015 out_tag  output  TAG_W  tag of the request producing out_data.
REQ-016 out_ready  input  1  consumer takes result when out_valid && out_ready.

Function
REQ-017 Accepted requests SHALL enter a DEPTH-entry FIFO of {tag, in_data_1, in_data_2}; in_ready SHALL equal !full.
REQ-018 Each accepted request SHALL receive the current tag counter value; the counter SHALL increment by 1 per accept and wrap modulo 2^TAG_W.
REQ-019 A request written in cycle N SHALL be poppable no earlier than cycle N+1; a pop and a push in the same cycle SHALL both take effect with occupancy unchanged.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: FIFO non-empty -> pop head into root_data_1, root_data_2, and the current tag; go to ISSUE. Otherwise stay in IDLE.
REQ-022 ISSUE: root_in_valid SHALL be 1 for exactly this one cycle; go to WAIT.
REQ-023 WAIT: on root_out_valid, register root_out_data into out_data and the current tag into out_tag, and set out_valid=1 from the next cycle; go to RESP.
REQ-024 RESP: out_valid held 1, out_data and out_tag held stable until out_valid && out_ready; on that cycle go to IDLE, with out_valid=0 from the next cycle.
REQ-025 root_data_1 and root_data_2 SHALL stay constant from the ISSUE cycle until the next pop; the engine samples them combinationally for the whole computation.
REQ-026 The next root_in_valid SHALL be at least 3 cycles after the root_out_valid cycle, letting the engine return to its idle state; the IDLE/RESP path guarantees this.
REQ-027 root_out_valid outside WAIT SHALL be ignored.
REQ-028 At most one request SHALL be in flight in the engine; engine latency is unbounded from this block's view.
REQ-029 Results SHALL leave in acceptance order; out_data SHALL be passed bit-exact, with no arithmetic performed.
REQ-030 While out_ready=0, further FIFO accepts SHALL continue until full; no issue occurs until RESP completes.

Reset
REQ-031 While rst_n=0, independent of clk: FIFO empty, tag counter 0, state IDLE, root_in_valid 0, root_data_1 0, root_data_2 0, out_valid 0, out_data 0, out_tag 0.
REQ-032 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-033 Reset asserted mid-operation (WAIT or RESP) SHALL discard the in-flight and queued requests; any root_out_valid arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-034 Single request: in_data_1=16, in_data_2=2 sent, engine model returns 20'h01000 after 40 cycles -> one root_in_valid pulse with root_data_1=16 and root_data_2=2; out_valid with out_data=20'h01000 and out_tag=0.
REQ-035 Back-to-back burst: 6 requests with out_ready=1 -> in_ready drops after 4 accepted plus 1 in flight; results return in order with tags 0..5; root_in_valid pulses spaced at least 3 cycles after each root_out_valid.
REQ-036 Backpressure: out_ready=0 for 50 cycles -> out_valid, out_data, and out_tag stable throughout; no root_in_valid; accepting resumes after the handshake.
REQ-037 Tag wrap: 17 requests -> 17th result carries out_tag=0.
REQ-038 Async reset asserted during WAIT with 3 queued requests -> all outputs 0 immediately; in_ready=1 after release; a late root_out_valid produces no out_valid.
REQ-039 Stray root_out_valid while in IDLE -> no out_valid and no state change.

Source files
------------

// File: rtl/root_dispatch.sv
// -----------------------------------------------------------------------------
// root_dispatch
//
// Front end for a single, shared root engine. Requests are queued in a small
// FIFO together with a sequence tag, issued to the engine one at a time, and
// the engine's Q10.10 result is returned to the consumer along with the tag of
// the request that produced it. Results therefore leave in acceptance order.
//
// Parameters
//   DEPTH  request FIFO depth (power of 2, >= 2)
//   TAG_W  width of the request tag / tag counter
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is simply "FIFO not full"
//   in_data_1           radicand (unsigned, 10 bits)
//   in_data_2           root order (3 bits)
//   root_in_valid       one-cycle start pulse to the engine
//   root_data_1/_2      operands held steady for the whole engine computation
//   root_out_valid      engine result strobe (only honoured while waiting)
//   root_out_data       engine result, Q10.10
//   out_valid/out_ready result handshake
//   out_data, out_tag   result and the tag of the originating request
// -----------------------------------------------------------------------------
module root_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [9:0]       in_data_1,
  input  logic [2:0]       in_data_2,
  output logic             in_ready,
  output logic             root_in_valid,
  output logic [9:0]       root_data_1,
  output logic [2:0]       root_data_2,
  input  logic             root_out_valid,
  input  logic [19:0]      root_out_data,
  output logic             out_valid,
  output logic [19:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          ENT_W    = TAG_W + 13;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // FIFO storage and control
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;

  // Dispatch FSM and its registered outputs
  state_t           state_q, state_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [9:0]       root_data_1_q, root_data_1_d;
  logic [2:0]       root_data_2_q, root_data_2_d;
  logic             out_valid_q, out_valid_d;
  logic [19:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Popping is decided from the registered count, so an entry written this
  // cycle can only be seen by the FSM on the following cycle.
  assign pop      = (state_q == IDLE) && !empty;
  assign head     = mem_q[rd_ptr_q];

  // FIFO payload carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_cnt_q, in_data_1, in_data_2};
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_cnt_d = tag_cnt_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      tag_cnt_d = tag_cnt_q + TAG_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cur_tag_d     = cur_tag_q;
    root_data_1_d = root_data_1_q;
    root_data_2_d = root_data_2_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_tag_d     = out_tag_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          // Operands stay latched here until the next pop, so the engine may
          // read them combinationally throughout its computation.
          {cur_tag_d, root_data_1_d, root_data_2_d} = head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (root_out_valid) begin
          out_data_d  = root_out_data;
          out_tag_d   = cur_tag_q;
          out_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // The RESP -> IDLE -> ISSUE path also spaces the next start pulse
        // three cycles after the result strobe, giving the engine time to
        // settle back to idle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tag_cnt_q     <= '0;
      state_q       <= IDLE;
      cur_tag_q     <= '0;
      root_data_1_q <= '0;
      root_data_2_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_tag_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_cnt_q     <= tag_cnt_d;
      state_q       <= state_d;
      cur_tag_q     <= cur_tag_d;
      root_data_1_q <= root_data_1_d;
      root_data_2_q <= root_data_2_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign root_in_valid = (state_q == ISSUE);
  assign root_data_1   = root_data_1_q;
  assign root_data_2   = root_data_2_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_root_dispatch.sv
module tb_root_dispatch;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [9:0]       in_data_1;
  logic [2:0]       in_data_2;
  logic             in_ready;
  logic             root_in_valid;
  logic [9:0]       root_data_1;
  logic [2:0]       root_data_2;
  logic             root_out_valid;
  logic [19:0]      root_out_data;
  logic             out_valid;
  logic [19:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready;

  // Engine-model drive and stray-pulse drive kept apart, merged here.
  logic        eng_vld;
  logic [19:0] eng_dat;
  logic        stray_vld;
  logic [19:0] stray_dat;
  assign root_out_valid = eng_vld | stray_vld;
  assign root_out_data  = eng_vld ? eng_dat : stray_dat;

  root_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data_1      (in_data_1),
    .in_data_2      (in_data_2),
    .in_ready       (in_ready),
    .root_in_valid  (root_in_valid),
    .root_data_1    (root_data_1),
    .root_data_2    (root_data_2),
    .root_out_valid (root_out_valid),
    .root_out_data  (root_out_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_tag        (out_tag),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed;
  int total;

  // Engine model configuration (written by the test tasks only)
  int          eng_lat     = 5;
  logic        eng_fixed_en = 1'b0;
  logic [19:0] eng_fixed   = 20'h0;

  // Engine model statistics (written by the engine process only)
  int          issues       = 0;
  int          gap_bad      = 0;
  int          hold_err     = 0;
  int          last_out_cyc = -1000;
  logic [9:0]  last_d1;
  logic [2:0]  last_d2;
  logic [9:0]  e_d1;
  logic [2:0]  e_d2;
  logic        e_abort;

  // Results seen leaving the DUT (written by the monitor only)
  logic [19:0]      res_q[$];
  logic [TAG_W-1:0] tag_q[$];

  // Arbitrary but request-dependent engine answer, so ordering is visible.
  function automatic logic [19:0] eng_f(input logic [9:0] a, input logic [2:0] b);
    return {a, 7'd0, b};
  endfunction

  // Root engine model: samples at negedge, answers after eng_lat cycles.
  initial begin
    eng_vld = 1'b0;
    eng_dat = 20'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && root_in_valid === 1'b1) begin
        issues++;
        if (cyc - last_out_cyc < 3) gap_bad++;
        e_d1    = root_data_1;
        e_d2    = root_data_2;
        last_d1 = root_data_1;
        last_d2 = root_data_2;
        e_abort = 1'b0;
        for (int i = 0; i < eng_lat - 1; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            e_abort = 1'b1;
            break;
          end
          if (root_data_1 !== e_d1 || root_data_2 !== e_d2) hold_err++;
        end
        if (!e_abort) begin
          eng_dat      = eng_fixed_en ? eng_fixed : eng_f(e_d1, e_d2);
          eng_vld      = 1'b1;
          last_out_cyc = cyc;
          @(negedge clk);
          eng_vld = 1'b0;
        end
      end
    end
  end

  // Result monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        res_q.push_back(out_data);
        tag_q.push_back(out_tag);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b0;
    stray_vld = 1'b0;
    stray_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [9:0] a, input logic [2:0] b, output logic rdy0);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    @(negedge clk);
    rdy0 = in_ready;
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      $display("FAIL send_timeout: in_ready=%b after 500 cycles, expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int bound);
    int t;
    t = 0;
    while (res_q.size() < n && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (res_q.size() < n) begin
      total++;
      $display("FAIL wait_results: got %0d results, expected %0d", res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b0;
    stray_vld = 1'b0;
    stray_dat = '0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (root_in_valid !== 1'b0) $display("FAIL rst_root_in_valid: got %b expected 0", root_in_valid); else passed++;
    total++; if (root_data_1 !== 10'd0) $display("FAIL rst_root_data_1: got %h expected 0", root_data_1); else passed++;
    total++; if (root_data_2 !== 3'd0) $display("FAIL rst_root_data_2: got %h expected 0", root_data_2); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 20'd0) $display("FAIL rst_out_data: got %h expected 0", out_data); else passed++;
    total++; if (out_tag !== 4'd0) $display("FAIL rst_out_tag: got %h expected 0", out_tag); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid_after: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_single();
    int   bi, br;
    logic r;
    do_reset();
    eng_lat      = 40;
    eng_fixed_en = 1'b1;
    eng_fixed    = 20'h01000;
    out_ready    = 1'b1;
    bi = issues;
    br = res_q.size();
    send(10'd16, 3'd2, r);
    wait_results(br + 1, 200);
    repeat (5) @(negedge clk);
    total++; if (issues - bi !== 1) $display("FAIL single_issues: got %0d expected 1", issues - bi); else passed++;
    total++; if (last_d1 !== 10'd16) $display("FAIL single_root_data_1: got %0d expected 16", last_d1); else passed++;
    total++; if (last_d2 !== 3'd2) $display("FAIL single_root_data_2: got %0d expected 2", last_d2); else passed++;
    total++; if (res_q.size() !== br + 1) $display("FAIL single_count: got %0d expected %0d", res_q.size(), br + 1); else passed++;
    if (res_q.size() > br) begin
      total++; if (res_q[br] !== 20'h01000) $display("FAIL single_data: got %h expected 01000", res_q[br]); else passed++;
      total++; if (tag_q[br] !== 4'd0) $display("FAIL single_tag: got %0d expected 0", tag_q[br]); else passed++;
    end
    total++; if (out_valid !== 1'b0) $display("FAIL single_out_valid_drop: got %b expected 0", out_valid); else passed++;
    eng_fixed_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   bi, br, gb, he, first_drop;
    logic r;
    do_reset();
    eng_lat   = 5;
    out_ready = 1'b1;
    bi = issues;
    br = res_q.size();
    gb = gap_bad;
    he = hold_err;
    first_drop = -1;
    for (int k = 0; k < 6; k++) begin
      send(10'(37 * k + 5), 3'(k), r);
      if (r !== 1'b1 && first_drop < 0) first_drop = k;
    end
    total++; if (first_drop !== 5) $display("FAIL b2b_ready_drop: in_ready first low at request %0d expected 5", first_drop); else passed++;
    wait_results(br + 6, 500);
    for (int k = 0; k < 6; k++) begin
      if (res_q.size() > br + k) begin
        total++; if (res_q[br + k] !== eng_f(10'(37 * k + 5), 3'(k)))
          $display("FAIL b2b_data[%0d]: got %h expected %h", k, res_q[br + k], eng_f(10'(37 * k + 5), 3'(k))); else passed++;
        total++; if (tag_q[br + k] !== 4'(k))
          $display("FAIL b2b_tag[%0d]: got %0d expected %0d", k, tag_q[br + k], k); else passed++;
      end
    end
    total++; if (gap_bad !== gb) $display("FAIL b2b_issue_gap: %0d short gaps, expected 0", gap_bad - gb); else passed++;
    total++; if (hold_err !== he) $display("FAIL b2b_operand_hold: %0d changes, expected 0", hold_err - he); else passed++;
    total++; if (issues - bi !== 6) $display("FAIL b2b_issues: got %0d expected 6", issues - bi); else passed++;
  endtask

  task automatic test_backpressure();
    int   bi, br, t;
    logic r;
    do_reset();
    eng_lat   = 5;
    out_ready = 1'b0;
    br = res_q.size();
    for (int k = 0; k < 5; k++) send(10'(100 + k), 3'(k + 2), r);
    t = 0;
    while (out_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    bi = issues;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_tag} !== {1'b1, eng_f(10'd100, 3'd2), 4'd0})
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h t=%0d expected v=1 d=%h t=0",
                 i, out_valid, out_data, out_tag, eng_f(10'd100, 3'd2));
      else passed++;
    end
    total++; if (issues !== bi) $display("FAIL bp_no_issue: got %0d issues expected 0", issues - bi); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%b expected 0", in_ready); else passed++;
    @(posedge clk);
    #1 out_ready = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    total++; if (in_ready !== 1'b1) $display("FAIL bp_resume: in_ready=%b expected 1", in_ready); else passed++;
    send(10'd200, 3'd1, r);
    wait_results(br + 6, 500);
    for (int k = 0; k < 5; k++) begin
      if (res_q.size() > br + k) begin
        total++; if (res_q[br + k] !== eng_f(10'(100 + k), 3'(k + 2)))
          $display("FAIL bp_data[%0d]: got %h expected %h", k, res_q[br + k], eng_f(10'(100 + k), 3'(k + 2))); else passed++;
        total++; if (tag_q[br + k] !== 4'(k))
          $display("FAIL bp_tag[%0d]: got %0d expected %0d", k, tag_q[br + k], k); else passed++;
      end
    end
    if (res_q.size() > br + 5) begin
      total++; if (res_q[br + 5] !== eng_f(10'd200, 3'd1))
        $display("FAIL bp_data[5]: got %h expected %h", res_q[br + 5], eng_f(10'd200, 3'd1)); else passed++;
      total++; if (tag_q[br + 5] !== 4'd5) $display("FAIL bp_tag[5]: got %0d expected 5", tag_q[br + 5]); else passed++;
    end
  endtask

  task automatic test_tag_wrap();
    int   br;
    logic r;
    do_reset();
    eng_lat   = 2;
    out_ready = 1'b1;
    br = res_q.size();
    for (int k = 0; k < 17; k++) send(10'(k * 50 + 1), 3'(k % 8), r);
    wait_results(br + 17, 1000);
    if (res_q.size() > br + 16) begin
      total++; if (tag_q[br + 15] !== 4'd15) $display("FAIL wrap_tag15: got %0d expected 15", tag_q[br + 15]); else passed++;
      total++; if (tag_q[br + 16] !== 4'd0) $display("FAIL wrap_tag16: got %0d expected 0", tag_q[br + 16]); else passed++;
      total++; if (res_q[br + 16] !== eng_f(10'd801, 3'd0))
        $display("FAIL wrap_data16: got %h expected %h", res_q[br + 16], eng_f(10'd801, 3'd0)); else passed++;
    end
  endtask

  task automatic test_stray();
    int   bi, br;
    logic r;
    do_reset();
    out_ready = 1'b0;
    bi = issues;
    br = res_q.size();
    @(posedge clk);
    #1 stray_dat = 20'hABCDE;
    stray_vld = 1'b1;
    @(posedge clk);
    #1 stray_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) $display("FAIL stray_out_valid cycle %0d: got %b expected 0", i, out_valid); else passed++;
    end
    total++; if (issues !== bi) $display("FAIL stray_issue: got %0d issues expected 0", issues - bi); else passed++;
    @(posedge clk);
    #1 out_ready = 1'b1;
    eng_lat = 3;
    send(10'd5, 3'd3, r);
    wait_results(br + 1, 200);
    if (res_q.size() > br) begin
      total++; if (res_q[br] !== eng_f(10'd5, 3'd3)) $display("FAIL stray_next_data: got %h expected %h", res_q[br], eng_f(10'd5, 3'd3)); else passed++;
      total++; if (tag_q[br] !== 4'd0) $display("FAIL stray_next_tag: got %0d expected 0", tag_q[br]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int   bi, br;
    logic r;
    do_reset();
    eng_lat   = 4;
    out_ready = 1'b1;
    br = res_q.size();
    send(10'd123, 3'd4, r);
    wait_results(br + 1, 100);
    eng_lat = 30;
    bi = issues;
    for (int k = 0; k < 4; k++) send(10'(200 + k), 3'(k), r);
    repeat (3) @(negedge clk);
    total++; if (issues - bi !== 1) $display("FAIL mid_in_flight: got %0d issues expected 1", issues - bi); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_pre_out_valid: got %b expected 0", out_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (root_in_valid !== 1'b0) $display("FAIL mid_root_in_valid: got %b expected 0", root_in_valid); else passed++;
    total++; if (root_data_1 !== 10'd0) $display("FAIL mid_root_data_1: got %0d expected 0", root_data_1); else passed++;
    total++; if (root_data_2 !== 3'd0) $display("FAIL mid_root_data_2: got %0d expected 0", root_data_2); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 20'd0) $display("FAIL mid_out_data: got %h expected 0", out_data); else passed++;
    total++; if (out_tag !== 4'd0) $display("FAIL mid_out_tag: got %0d expected 0", out_tag); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else passed++;
    @(posedge clk);
    #1 stray_dat = 20'h12345;
    stray_vld = 1'b1;
    @(posedge clk);
    #1 stray_vld = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL mid_late_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (issues - bi !== 1) $display("FAIL mid_queue_discard: got %0d issues expected 1", issues - bi); else passed++;
    total++; if (res_q.size() !== br + 1) $display("FAIL mid_results: got %0d expected %0d", res_q.size(), br + 1); else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    stray_vld = 1'b0;
    stray_dat = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_tag_wrap();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
